noc_inject_ni: RTL and testbench

//   Network-interface injector in front of one 3x1 router input port (A/B/C).

---
 rtl/noc_pkg.sv | 46 ++++
 rtl/noc_flit_outreg.sv | 42 ++++
 rtl/noc_inject_ni.sv | 98 +++++++++
 tb/tb_noc_inject_ni.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared definitions for the NoC network interfaces: flit field layout,
// injector FSM states and the header-flit builder.
package noc_pkg;

  localparam int FLIT_W    = 32;
  localparam int PLD_W     = 30;
  localparam int FLIT_PRIO = 31;
  localparam int FLIT_HEAD = 30;
  localparam int DEST_MSB  = 29;
  localparam int DEST_LSB  = 22;
  localparam int LEN_MSB   = 21;
  localparam int LEN_LSB   = 18;
  localparam int SRC_MSB   = 17;
  localparam int SRC_LSB   = 10;
  localparam int SEQ_MSB   = 9;
  localparam int SEQ_LSB   = 0;

  localparam int DEST_W = DEST_MSB - DEST_LSB + 1;
  localparam int LEN_W  = LEN_MSB - LEN_LSB + 1;
  localparam int SRC_W  = SRC_MSB - SRC_LSB + 1;
  localparam int SEQ_W  = SEQ_MSB - SEQ_LSB + 1;

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } ni_state_e;

  function automatic logic [FLIT_W-1:0] mk_header(
    input logic              prio,
    input logic [DEST_W-1:0] dest,
    input logic [LEN_W-1:0]  len,
    input logic [SRC_W-1:0]  src,
    input logic [SEQ_W-1:0]  seq
  );
    logic [FLIT_W-1:0] f;
    f                   = '0;
    f[FLIT_PRIO]        = prio;
    f[FLIT_HEAD]        = 1'b1;
    f[DEST_MSB:DEST_LSB] = dest;
    f[LEN_MSB:LEN_LSB]  = len;
    f[SRC_MSB:SRC_LSB]  = src;
    f[SEQ_MSB:SEQ_LSB]  = seq;
    return f;
  endfunction

endpackage

// File: rtl/noc_flit_outreg.sv
// Single-entry valid/ready output register. Loads only when the slot is free,
// so a presented flit stays stable until the downstream side takes it.
module noc_flit_outreg #(
  parameter int Width = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             free_o
);

  logic [Width-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  assign free_o  = !valid_q || ready_i;
  assign data_o  = data_q;
  assign valid_o = valid_q;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (free_o) begin
      valid_d = load_i;
      if (load_i) data_d = data_i;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/noc_inject_ni.sv
// Injection NI: turns a packet request plus a payload word stream into a
// header flit followed by ReqLen payload flits on a valid/ready link.
module noc_inject_ni
  import noc_pkg::*;
#(
  parameter logic [7:0] SrcId    = 8'h00,
  parameter int         LenWidth = LEN_W
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                ReqValid_i,
  output logic                ReqReady_o,
  input  logic [7:0]          ReqDest_i,
  input  logic                ReqPrio_i,
  input  logic [LenWidth-1:0] ReqLen_i,
  input  logic [29:0]         PldData_i,
  input  logic                PldValid_i,
  output logic                PldReady_o,
  output logic [31:0]         Data_o,
  output logic                Valid_o,
  input  logic                Ready_i,
  output logic                Busy_o
);

  ni_state_e           state_q;
  logic [LenWidth-1:0] rem_q;
  logic [SEQ_W-1:0]    seq_q;
  logic                prio_q;
  logic                en_q;

  logic                free;
  logic                req_fire;
  logic                pld_fire;
  logic                load;
  logic [FLIT_W-1:0]   load_data;

  // en_q keeps both ready outputs low while reset is asserted and for the
  // first cycle after release, independent of the output register state.
  assign ReqReady_o = en_q && (state_q == IDLE) && free;
  assign PldReady_o = en_q && (state_q == BODY) && free;
  assign req_fire   = ReqValid_i && ReqReady_o;
  assign pld_fire   = PldValid_i && PldReady_o;
  assign Busy_o     = (state_q != IDLE) || Valid_o;

  always_comb begin
    load      = 1'b0;
    load_data = mk_header(ReqPrio_i, ReqDest_i, ReqLen_i, SrcId, seq_q);
    if (req_fire) begin
      load = 1'b1;
    end else if (pld_fire) begin
      load      = 1'b1;
      load_data = {prio_q, 1'b0, PldData_i};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      rem_q   <= '0;
      seq_q   <= '0;
      prio_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      en_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (req_fire) begin
            prio_q <= ReqPrio_i;
            rem_q  <= ReqLen_i;
            seq_q  <= seq_q + 1'b1;
            if (ReqLen_i != '0) state_q <= BODY;
          end
        end
        BODY: begin
          if (pld_fire) begin
            rem_q <= rem_q - 1'b1;
            if (rem_q == LenWidth'(1)) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  noc_flit_outreg #(
    .Width(FLIT_W)
  ) u_outreg (
    .clk    (clk),
    .rstn   (rstn),
    .load_i (load),
    .data_i (load_data),
    .data_o (Data_o),
    .valid_o(Valid_o),
    .ready_i(Ready_i),
    .free_o (free)
  );

endmodule

// File: tb/tb_noc_inject_ni.sv
// Bench for noc_inject_ni: directed steps plus randomized traffic, checked
// against a packet-level expected-flit queue built from the requests issued.
module tb_noc_inject_ni;

  localparam logic [7:0] SRC = 8'h00;
  localparam int         TMO = 400;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        ReqValid_i = 1'b0;
  logic        ReqReady_o;
  logic [7:0]  ReqDest_i = 8'h00;
  logic        ReqPrio_i = 1'b0;
  logic [3:0]  ReqLen_i = 4'h0;
  logic [29:0] PldData_i = 30'h0;
  logic        PldValid_i = 1'b0;
  logic        PldReady_o;
  logic [31:0] Data_o;
  logic        Valid_o;
  logic        Ready_i = 1'b0;
  logic        Busy_o;

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_xfer = 0;
  int          exp_flits = 0;
  int          rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random
  bit          mon_en = 1'b0;
  bit          in_body = 1'b0;
  bit          stall_prev = 1'b0;
  logic [31:0] data_prev = 32'h0;
  logic [9:0]  model_seq = 10'h0;
  logic [31:0] exp_q[$];

  noc_inject_ni #(.SrcId(SRC), .LenWidth(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .ReqValid_i(ReqValid_i),
    .ReqReady_o(ReqReady_o),
    .ReqDest_i (ReqDest_i),
    .ReqPrio_i (ReqPrio_i),
    .ReqLen_i  (ReqLen_i),
    .PldData_i (PldData_i),
    .PldValid_i(PldValid_i),
    .PldReady_o(PldReady_o),
    .Data_o    (Data_o),
    .Valid_o   (Valid_o),
    .Ready_i   (Ready_i),
    .Busy_o    (Busy_o)
  );

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0:       Ready_i = 1'b0;
      1:       Ready_i = 1'b1;
      default: Ready_i = 1'($urandom % 2);
    endcase
  end

  function automatic logic [31:0] hdr_flit(input logic prio, input logic [7:0] dest,
                                           input logic [3:0] len, input logic [9:0] seq);
    return {prio, 1'b1, dest, len, SRC, seq};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_checks++;
    n_fail++;
    $error("FAIL %s observed=timeout expected=handshake", tag);
  endtask

  // Scoreboard / protocol monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (stall_prev) begin
        chk("hold_valid", 64'(Valid_o), 64'd1);
        chk("hold_data", 64'(Data_o), 64'(data_prev));
      end
      if (Valid_o && !Ready_i) chk("stall_core_rdy", {62'd0, ReqReady_o, PldReady_o}, 64'd0);
      if (in_body) chk("body_reqready", 64'(ReqReady_o), 64'd0);
      else         chk("idle_pldready", 64'(PldReady_o), 64'd0);
      if (Valid_o && Ready_i) begin
        n_xfer++;
        if (exp_q.size() == 0) timeout("extra_flit");
        else chk("flit", 64'(Data_o), 64'(exp_q.pop_front()));
      end
      stall_prev = Valid_o && !Ready_i;
      data_prev  = Data_o;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    #1;
    rstn = 1'b0;
    #1;
    chk("rst_valid", 64'(Valid_o), 64'd0);
    chk("rst_data", 64'(Data_o), 64'd0);
    chk("rst_reqready", 64'(ReqReady_o), 64'd0);
    chk("rst_pldready", 64'(PldReady_o), 64'd0);
    chk("rst_busy", 64'(Busy_o), 64'd0);
    exp_q.delete();
    in_body    = 1'b0;
    model_seq  = 10'h0;
    n_xfer     = 0;
    exp_flits  = 0;
    stall_prev = 1'b0;
    ReqValid_i = 1'b0;
    PldValid_i = 1'b0;
    repeat (3) cyc();
    rstn = 1'b1;
    cyc();
    mon_en = 1'b1;
  endtask

  task automatic send_pkt(input logic [7:0] dest, input logic prio, input logic [3:0] len,
                          input int stop_after, input bit gaps);
    logic [29:0] pld[16];
    int          k;
    for (int i = 0; i < 16; i++) pld[i] = 30'($urandom);
    exp_q.push_back(hdr_flit(prio, dest, len, model_seq));
    for (int i = 0; i < int'(len); i++) exp_q.push_back({prio, 1'b0, pld[i]});
    model_seq = model_seq + 10'd1;
    exp_flits += int'(len) + 1;
    ReqValid_i = 1'b1;
    ReqDest_i  = dest;
    ReqPrio_i  = prio;
    ReqLen_i   = len;
    PldValid_i = gaps ? 1'($urandom % 2) : 1'b0;   // junk offered while idle
    PldData_i  = 30'($urandom);
    k = 0;
    forever begin
      @(negedge clk);
      if (ReqReady_o) break;
      k++;
      if (k >= TMO) begin
        timeout("req_accept");
        ReqValid_i = 1'b0;
        PldValid_i = 1'b0;
        return;
      end
      cyc();
    end
    cyc();
    ReqValid_i = 1'b0;
    PldValid_i = 1'b0;
    in_body    = (len != 4'd0);
    for (int i = 0; i < int'(len); i++) begin
      if (i == stop_after) return;
      while (gaps && ($urandom % 2 == 1)) cyc();
      PldValid_i = 1'b1;
      PldData_i  = pld[i];
      k = 0;
      forever begin
        @(negedge clk);
        if (PldReady_o) break;
        k++;
        if (k >= TMO) begin
          timeout("pld_accept");
          PldValid_i = 1'b0;
          return;
        end
        cyc();
      end
      cyc();
      PldValid_i = 1'b0;
      if (i == int'(len) - 1) in_body = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 4000) begin
      cyc();
      k++;
    end
    chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_count"}, 64'(n_xfer), 64'(exp_flits));
    @(negedge clk);
    chk({tag, "_idle_busy"}, 64'(Busy_o), 64'd0);
    cyc();
  endtask

  initial begin
    logic [31:0] h;
    cyc();
    do_reset();

    // 1: basic packet, header one cycle after accept, payloads back to back
    rdy_mode = 1;
    cyc();
    h = hdr_flit(1'b0, 8'h05, 4'd2, model_seq);
    exp_q.push_back(h);
    exp_q.push_back(32'h0000_0001);
    exp_q.push_back(32'h0000_0002);
    model_seq = model_seq + 10'd1;
    exp_flits += 3;
    ReqValid_i = 1'b1; ReqDest_i = 8'h05; ReqPrio_i = 1'b0; ReqLen_i = 4'd2;
    @(negedge clk);
    chk("t1_reqready", 64'(ReqReady_o), 64'd1);
    cyc();
    ReqValid_i = 1'b0; in_body = 1'b1; PldValid_i = 1'b1; PldData_i = 30'h1;
    @(negedge clk);
    chk("t1_hdr", {31'd0, Valid_o, Data_o}, {31'd0, 1'b1, h});
    chk("t1_pldready", 64'(PldReady_o), 64'd1);
    cyc();
    PldData_i = 30'h2;
    @(negedge clk);
    chk("t1_pld1", {31'd0, Valid_o, Data_o}, {31'd0, 1'b1, 32'h1});
    cyc();
    PldValid_i = 1'b0; in_body = 1'b0;
    @(negedge clk);
    chk("t1_pld2", {31'd0, Valid_o, Data_o}, {31'd0, 1'b1, 32'h2});
    cyc();
    drain("t1");

    // 2: priority header-only packet with junk payload words offered
    send_pkt(8'hA3, 1'b1, 4'd0, -1, 1'b1);
    drain("t2");

    // 3: header stalled by Ready_i low for five cycles
    @(negedge clk);
    rdy_mode = 0;
    cyc();
    cyc();
    h = hdr_flit(1'b0, 8'h33, 4'd1, model_seq);
    exp_q.push_back(h);
    exp_q.push_back({1'b0, 1'b0, 30'h2AAA_5555});
    model_seq = model_seq + 10'd1;
    exp_flits += 2;
    ReqValid_i = 1'b1; ReqDest_i = 8'h33; ReqPrio_i = 1'b0; ReqLen_i = 4'd1;
    @(negedge clk);
    chk("t3_reqready", 64'(ReqReady_o), 64'd1);
    cyc();
    ReqValid_i = 1'b0; in_body = 1'b1; PldValid_i = 1'b1; PldData_i = 30'h2AAA_5555;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_valid", 64'(Valid_o), 64'd1);
      chk("t3_data", 64'(Data_o), 64'(h));
      chk("t3_core_rdy", {62'd0, ReqReady_o, PldReady_o}, 64'd0);
      if (i == 4) rdy_mode = 1;
      cyc();
    end
    @(negedge clk);
    chk("t3_release_pldready", 64'(PldReady_o), 64'd1);
    cyc();
    PldValid_i = 1'b0; in_body = 1'b0;
    drain("t3");

    // 4: sequence number wrap over 1025 header-only packets
    do_reset();
    for (int p = 0; p < 1025; p++) send_pkt(8'(p), 1'(p % 2), 4'd0, -1, 1'b0);
    drain("t4");
    chk("t4_model_seq", 64'(model_seq), 64'd1);

    // 5: random traffic with random backpressure and payload gaps
    rdy_mode = 2;
    for (int p = 0; p < 200; p++)
      send_pkt(8'($urandom), 1'($urandom % 2), 4'($urandom % 16), -1, 1'b1);
    drain("t5");
    rdy_mode = 1;
    cyc();

    // 6: asynchronous reset in the middle of a 15-payload packet
    send_pkt(8'h7E, 1'b1, 4'd15, 7, 1'b0);
    chk("t6_pre_reset_busy", 64'(Busy_o), 64'd1);
    do_reset();
    send_pkt(8'h11, 1'b0, 4'd3, -1, 1'b0);
    drain("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=end_of_test");
    $fatal(1, "simulation time limit reached");
  end

endmodule
